fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation CPU core.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake, tolerating multi-cycle memory latency.
- Buffers fetched instructions with their PCs in a DEPTH-entry FIFO toward decode.
- Accepts branch/jump redirects that flush the buffer and discard any in-flight fetch.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.
- STEP, 4, PC increment per sequential fetch (byte addressing).

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  ADDR_W  fetch address, stable while imem_req=1.
- imem_ack  input  1  memory accepts the request and returns data this cycle.
- imem_rdata  input  DATA_W  instruction word, valid when imem_ack=1.
- redirect_valid  input  1  branch taken / jump this cycle.
- redirect_pc  input  ADDR_W  new PC; low 2 bits forced to 0.
- instr_valid  output  1  FIFO head valid.
- instr_data  output  DATA_W  FIFO head instruction.
- instr_pc  output  ADDR_W  PC of FIFO head.
- instr_ready  input  1  decode consumes the head when instr_valid=1.
- fifo_count  output  $clog2(DEPTH+1)  entries currently buffered.

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty, fifo_count=0, instr_valid=0, instr_data=0, instr_pc=0.
- FSM states: IDLE (no request), FETCH (imem_req=1, addr=req_addr), DROP (imem_req=1, response to be discarded).
- imem_addr is driven from req_addr, a register distinct from pc.
- Memory rule: once imem_req=1, imem_req and imem_addr stay constant until the cycle imem_ack=1. ack may arrive in the first req cycle. At most one request is outstanding.
- IDLE:
  - If redirect_valid: pc=redirect_pc.
  - If fifo_count_next < DEPTH: go to FETCH with req_addr = the updated pc. imem_req rises the cycle after the edge.
- FETCH, ack=1, no redirect:
  - Push {req_addr, imem_rdata}; pc = req_addr + STEP, wrapping mod 2^ADDR_W.
  - Next state is FETCH with req_addr = new pc if post-edge count < DEPTH, else IDLE.
  - Back-to-back fetches give one instruction per cycle with a 1-cycle memory.
- FETCH, ack=0, redirect: flush; pc = redirect_pc; go to DROP. req and addr are held.
- FETCH, ack=1, redirect: discard data; flush; pc = redirect_pc; go to FETCH with req_addr = redirect_pc.
- DROP:
  - On ack: discard data; go to FETCH at pc (FIFO is empty).
  - A further redirect while in DROP overwrites pc; this is legal in the same cycle as ack.
- FIFO:
  - Show-ahead: instr_valid = (count != 0); instr_data/instr_pc are the head entry.
  - Pop when instr_valid && instr_ready && !redirect_valid.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop when empty has no effect.
  - Push never occurs when full, guaranteed by the issue rule.
- Redirect has priority over pop and push. The flush makes count=0 at the edge, and instr_valid=0 the following cycle.
- Redirect latency: with no outstanding request, the first fetch at the target has imem_req=1 in the cycle after redirect_valid.
- When count==0, instr_data/instr_pc hold their last values; they are don't-care to decode but must not be X after reset.
- Reset asserted mid-transaction abandons the request immediately: imem_req=0 asynchronously. The memory must tolerate this.

Test Plan:
- Reset release, 1-cycle ack, instr_ready=1 -> imem_addr sequence 0,4,8,12; instr_pc 0,4,8 with matching data; fifo_count stays <=1.
- instr_ready=0, DEPTH=4, ack immediate -> exactly 4 pushes (addr 0..12), then imem_req=0 and fifo_count=4. One pop -> new request at addr 16 on the next cycle.
- ack delayed 3 cycles with redirect_pc=0x100 in cycle 1 of the wait -> imem_req/addr held at 0 until ack; that data is not pushed; next request addr=0x100; first instr_pc=0x100.
- Redirect coincident with ack and instr_ready with 2 buffered entries -> no pop counted, fifo_count=0 next cycle, ack data discarded, next imem_addr=redirect_pc.
- ADDR_W=8, RESET_PC=0xF8 -> addresses 0xF8, 0xFC, 0x00 (wrap). redirect_pc=0x33 -> fetch addr 0x30.
- Reset pulled low while imem_req=1 and FIFO holds 3 -> imem_req=0, fifo_count=0, instr_valid=0 without a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request port, redirect input and decode-side FIFO head.
// The master side is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic [CntW-1:0]   fifo_count;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready,
    output fifo_count
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready,
    input  fifo_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding word fetch at a time and
// buffers {pc, instruction} pairs in a show-ahead FIFO toward decode; redirects flush everything.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       STEP     = 4
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned       PtrW     = $clog2(DEPTH);
  localparam int unsigned       CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] StepAddr = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);

  typedef enum logic [1:0] {StIdle, StFetch, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_q, req_d;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] ipc_q  [DEPTH];
  logic [ADDR_W-1:0] ipc_d  [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_idx;

  logic              flush;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & WordMask;
  assign flush        = bus.redirect_valid;
  assign pop          = (count_q != '0) && bus.instr_ready && !flush;
  assign push         = (state_q == StFetch) && bus.imem_ack && !flush;

  // FIFO next state; a flush keeps the read pointer just past the last head shown.
  always_comb begin
    data_d   = data_q;
    ipc_d    = ipc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = (count_q != '0) ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.imem_rdata;
        ipc_d[wr_ptr_q]  = req_addr_q;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Fetch FSM; the issue decision looks at the post-edge count so a push never meets a full FIFO.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      StIdle: begin
        if (flush) begin
          pc_d = redirect_tgt;
        end
        if (count_d < DepthCnt) begin
          state_d    = StFetch;
          req_addr_d = pc_d;
        end
      end
      StFetch: begin
        if (flush) begin
          pc_d = redirect_tgt;
          if (bus.imem_ack) begin
            req_addr_d = redirect_tgt;
          end else begin
            state_d = StDrop;
          end
        end else if (bus.imem_ack) begin
          pc_d = req_addr_q + StepAddr;
          if (count_d < DepthCnt) begin
            req_addr_d = pc_d;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (flush) begin
          pc_d = redirect_tgt;
        end
        if (bus.imem_ack) begin
          state_d    = StFetch;
          req_addr_d = pc_d;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign req_d = (state_d != StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      ipc_q      <= ipc_d;
    end
  end

  // When empty, present the slot behind the read pointer so the outputs keep the last head.
  assign head_idx = (count_q == '0) ? rd_ptr_q - 1'b1 : rd_ptr_q;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_data  = data_q[head_idx];
  assign bus.instr_pc    = ipc_q[head_idx];
  assign bus.fifo_count  = count_q;

  push_not_full_a: assert property (@(posedge clock) disable iff (!reset)
    push |-> (count_q != DepthCnt));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable latency, instruction scoreboard,
// a redirect vector table and hand-written reset/flush sequences; second DUT covers 8-bit wrap.
module tb_fetch_unit;
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) m_if ();
  fetch_unit_if #(.ADDR_W(8),  .DATA_W(32), .DEPTH(4)) s_if ();

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .STEP(4)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (m_if.master)
  );

  fetch_unit #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(8'hF8), .STEP(4)
  ) u_dut8 (
    .clock(clock),
    .reset(reset),
    .bus  (s_if.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] ack_log[$];
  logic [7:0]  s_log[$];
  int          lat = 0;
  vec_t        vecs[4];

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (ack_log.size() > i) ? ack_log[i] : 32'hFFFF_FFFF;
  endfunction

  // Main memory: ack after `lat` wait cycles, checks the request holds while waiting.
  initial begin
    int          wait_cnt;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    wait_cnt  = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    m_if.imem_ack   = 1'b0;
    m_if.imem_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_if.imem_ack = 1'b0;
        wait_cnt = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (prev_req && !prev_ack && m_if.imem_req)
          chk("addr_hold", m_if.imem_addr, prev_addr);
        if (prev_ack || !m_if.imem_req) wait_cnt = 0;
        if (m_if.imem_req && wait_cnt >= lat) begin
          m_if.imem_ack   = 1'b1;
          m_if.imem_rdata = mdat(m_if.imem_addr);
          ack_log.push_back(m_if.imem_addr);
        end else begin
          m_if.imem_ack   = 1'b0;
          m_if.imem_rdata = 32'hDEAD_BEEF;
          if (m_if.imem_req) wait_cnt++;
        end
        prev_req  = m_if.imem_req;
        prev_ack  = m_if.imem_ack;
        prev_addr = m_if.imem_addr;
      end
    end
  end

  // Small DUT memory: always acks in the first request cycle.
  initial begin
    s_if.imem_ack   = 1'b0;
    s_if.imem_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset && s_if.imem_req) begin
        s_if.imem_ack   = 1'b1;
        s_if.imem_rdata = mdat({24'h0, s_if.imem_addr});
        s_log.push_back(s_if.imem_addr);
      end else begin
        s_if.imem_ack = 1'b0;
      end
    end
  end

  // Scoreboard: every head consumed by decode must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && m_if.instr_valid && m_if.instr_ready && !m_if.redirect_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got pc 0x%0h, expected no instruction", m_if.instr_pc);
        end else begin
          e = sb.pop_front();
          chk("instr_pc", m_if.instr_pc, e.pc);
          chk("instr_data", m_if.instr_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; consumes n sequential instructions starting at `start`.
  task automatic stream(input logic [31:0] start, input int n, input string name,
                        output int maxc);
    logic [31:0] a;
    exp_t        e;
    a    = start;
    maxc = 0;
    for (int i = 0; i < n; i++) begin
      e.pc   = a;
      e.data = mdat(a);
      sb.push_back(e);
      a += 32'd4;
    end
    m_if.instr_ready = 1'b1;
    for (int c = 0; c < 80 && sb.size() != 0; c++) begin
      @(posedge clock);
      #1;
      if (int'(m_if.fifo_count) > maxc) maxc = int'(m_if.fifo_count);
    end
    m_if.instr_ready = 1'b0;
    chk({name, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_if.redirect_valid = 1'b0;
    m_if.instr_ready    = 1'b0;
    s_if.redirect_valid = 1'b0;
    s_if.instr_ready    = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    ack_log.delete();
    s_log.delete();
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic wait_count(input int target, input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (int'(m_if.fifo_count) == target) break;
    end
    chk(name, m_if.fifo_count, target);
  endtask

  task automatic wait_req(input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (m_if.imem_req) break;
    end
    chk(name, m_if.imem_req, 1);
  endtask

  initial begin
    int maxc;
    vecs[0] = '{32'h0000_1000, 32'h0000_1000};
    vecs[1] = '{32'h0000_2003, 32'h0000_2000};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0047, 32'h0000_0044};

    reset = 1'b0;
    m_if.redirect_valid = 1'b0;
    m_if.redirect_pc    = '0;
    m_if.instr_ready    = 1'b0;
    s_if.redirect_valid = 1'b0;
    s_if.redirect_pc    = '0;
    s_if.instr_ready    = 1'b0;

    // Reset state
    #12;
    chk("rst_req",   m_if.imem_req, 0);
    chk("rst_addr",  m_if.imem_addr, 0);
    chk("rst_count", m_if.fifo_count, 0);
    chk("rst_valid", m_if.instr_valid, 0);
    chk("rst_data",  m_if.instr_data, 0);
    chk("rst_pc",    m_if.instr_pc, 0);
    chk("rst8_req",  s_if.imem_req, 0);
    chk("rst8_addr", s_if.imem_addr, 8'hF8);

    // Streaming with a 1-cycle memory and decode always ready
    lat = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    stream(32'h0, 3, "t1", maxc);
    chk("t1_maxcount_le1", (maxc <= 1), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_addr%0d", i), log_at(i), 32'(i * 4));

    // Fill to DEPTH, then a single pop reopens issue
    do_reset();
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("t2_count_full", m_if.fifo_count, 4);
    chk("t2_req_idle",   m_if.imem_req, 0);
    chk("t2_nacks",      ack_log.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_addr%0d", i), log_at(i), 32'(i * 4));
    @(posedge clock);
    #1;
    sb.push_back({32'h0, mdat(32'h0)});
    m_if.instr_ready = 1'b1;
    @(posedge clock);
    #1;
    m_if.instr_ready = 1'b0;
    chk("t2_count_after_pop", m_if.fifo_count, 3);
    @(negedge clock);
    chk("t2_req_after_pop",  m_if.imem_req, 1);
    chk("t2_addr_after_pop", m_if.imem_addr, 32'h10);
    chk("t2_sb_empty", sb.size(), 0);

    // Redirect while a 3-cycle fetch is outstanding: response dropped
    lat = 3;
    do_reset();
    wait_req("t3_first_req");
    @(posedge clock);
    #1;
    m_if.redirect_valid = 1'b1;
    m_if.redirect_pc    = 32'h100;
    @(posedge clock);
    #1;
    m_if.redirect_valid = 1'b0;
    @(negedge clock);
    chk("t3_req_held",  m_if.imem_req, 1);
    chk("t3_addr_held", m_if.imem_addr, 32'h0);
    chk("t3_count",     m_if.fifo_count, 0);
    @(posedge clock);
    #1;
    stream(32'h100, 2, "t3", maxc);
    chk("t3_ack0", log_at(0), 32'h0);
    chk("t3_ack1", log_at(1), 32'h100);

    // Redirect coincident with ack and ready, two entries buffered
    lat = 0;
    do_reset();
    wait_count(1, "t4_reach1");
    @(posedge clock);
    #1;
    m_if.redirect_valid = 1'b1;
    m_if.redirect_pc    = 32'h200;
    m_if.instr_ready    = 1'b1;
    @(negedge clock);
    chk("t4_pre_count", m_if.fifo_count, 2);
    chk("t4_pre_ack",   m_if.imem_ack, 1);
    @(posedge clock);
    #1;
    m_if.redirect_valid = 1'b0;
    m_if.instr_ready    = 1'b0;
    @(negedge clock);
    chk("t4_count", m_if.fifo_count, 0);
    chk("t4_valid", m_if.instr_valid, 0);
    chk("t4_req",   m_if.imem_req, 1);
    chk("t4_addr",  m_if.imem_addr, 32'h200);
    @(posedge clock);
    #1;
    stream(32'h200, 2, "t4", maxc);

    // Redirect vector table: alignment, latency and 32-bit wrap
    for (int i = 0; i < 4; i++) begin
      m_if.redirect_valid = 1'b1;
      m_if.redirect_pc    = vecs[i].rpc;
      @(posedge clock);
      #1;
      m_if.redirect_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d_req", i),   m_if.imem_req, 1);
      chk($sformatf("vec%0d_addr", i),  m_if.imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_count", i), m_if.fifo_count, 0);
      @(posedge clock);
      #1;
      stream(vecs[i].exp_addr, 2, $sformatf("vec%0d", i), maxc);
    end

    // Asynchronous reset with a request outstanding and three entries held
    do_reset();
    wait_count(3, "t6_reach3");
    chk("t6_pre_req", m_if.imem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req",   m_if.imem_req, 0);
    chk("t6_count", m_if.fifo_count, 0);
    chk("t6_valid", m_if.instr_valid, 0);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    ack_log.delete();
    reset = 1'b1;
    wait_req("t6_restart_req");
    chk("t6_restart_addr", m_if.imem_addr, 32'h0);

    // 8-bit address wrap and redirect alignment on the small instance
    do_reset();
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("t7_nacks",  s_log.size(), 4);
    chk("t7_addr0",  (s_log.size() > 0) ? s_log[0] : 8'h11, 8'hF8);
    chk("t7_addr1",  (s_log.size() > 1) ? s_log[1] : 8'h11, 8'hFC);
    chk("t7_addr2",  (s_log.size() > 2) ? s_log[2] : 8'h11, 8'h00);
    chk("t7_count",  s_if.fifo_count, 4);
    chk("t7_headpc", s_if.instr_pc, 8'hF8);
    chk("t7_headdata", s_if.instr_data, mdat(32'hF8));
    @(posedge clock);
    #1;
    s_if.redirect_valid = 1'b1;
    s_if.redirect_pc    = 8'h33;
    @(posedge clock);
    #1;
    s_if.redirect_valid = 1'b0;
    @(negedge clock);
    chk("t7_redir_req",   s_if.imem_req, 1);
    chk("t7_redir_addr",  s_if.imem_addr, 8'h30);
    chk("t7_redir_count", s_if.fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
